// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int GPR_W     = 5;
  localparam int DIV_CNT_W = 6;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc00380;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DIV   = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  // True when an ID source operand reads the register a producer writes.
  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic gpr_match(input logic             use_src,
                                     input logic [GPR_W-1:0] src,
                                     input logic [GPR_W-1:0] dst);
    return use_src && (src == dst) && (dst != '0);
  endfunction

endpackage

// File: rtl/pipe_div_seq.sv
// Divider occupancy sequencer: counts the EX-stage cycles a DIV/DIVU holds
// the pipeline and flags the last one. The counter is nonzero exactly while
// the controller is in its DIV state, so it doubles as the "in DIV" flag.
module pipe_div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hold,
  input  logic abort,
  output logic busy,
  output logic done
);

  // The start cycle is the first busy cycle, so the counter covers the
  // remaining DIV_CYCLES-1 cycles.
  localparam logic [DIV_CNT_W-1:0] LOAD_VAL = DIV_CNT_W'(DIV_CYCLES - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 active;

  assign active = (cnt_q != '0);
  assign busy   = active || (start && !abort);
  assign done   = (cnt_q == DIV_CNT_W'(1)) && !hold && !abort;

  // Next count: abort clears, wait states freeze, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (active) begin
      if (!hold) cnt_d = cnt_q - DIV_CNT_W'(1);
    end else if (start && !hold) begin
      cnt_d = LOAD_VAL;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional build macro HAZARD_PERF_CNT_EN adds per-cause stall counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal flow; combinational stalls/bubbles by priority
//   DIV   | divider occupies EX; front end held until the last cycle
//   FLUSH | one cycle: kill IF/ID, ID/EX, EX/MEM and redirect the PC
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GPR_W-1:0] id_rs,
  input  logic [GPR_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_is_load,
  input  logic             ex_write_reg,
  input  logic [GPR_W-1:0] ex_write_dst,
  input  logic             ex_div_start,
  input  logic             inst_sram_wait,
  input  logic             data_sram_wait,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  output logic             if_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             idex_bubble,
  output logic             flush,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             div_busy,
  output logic             div_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      loaduse_cnt,
  output logic [31:0]      div_stall_cnt,
  output logic [31:0]      mem_stall_cnt
`endif
);

  ctrl_state_e state_q, state_d;
  logic [31:0] rpc_q, rpc_d;

  logic flush_req;
  logic div_start;
  logic div_busy_w;
  logic div_done_w;
  logic load_use;
  logic stall_ok;

  assign flush_req = exc_req || eret_req;
  assign div_start = ex_div_start && (state_q == ST_RUN);
  // Stall causes only apply outside FLUSH and when no flush is being requested.
  assign stall_ok  = (state_q != ST_FLUSH) && !flush_req;

  assign load_use = ex_is_load && ex_write_reg &&
                    (gpr_match(id_use_rs, id_rs, ex_write_dst) ||
                     gpr_match(id_use_rt, id_rt, ex_write_dst));

  pipe_div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .hold  (data_sram_wait),
    .abort (flush_req),
    .busy  (div_busy_w),
    .done  (div_done_w)
  );

  // Next state: a flush request overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (div_start && !data_sram_wait) state_d = ST_DIV;
      ST_DIV:   if (div_done_w) state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (flush_req) state_d = ST_FLUSH;
  end

  // Redirect target capture; exception wins over ERET.
  always_comb begin
    rpc_d = rpc_q;
    if (exc_req)       rpc_d = EXC_VECTOR;
    else if (eret_req) rpc_d = epc;
  end

  // State and redirect registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
    end
  end

  // Stall/bubble/flush outputs by priority; held at zero while in reset.
  always_comb begin
    if_stall    = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = rpc_q;
    div_busy    = div_busy_w && rst_n;
    div_done    = div_done_w && rst_n;
    if (!rst_n) begin
      redirect_pc = '0;
    end else if (state_q == ST_FLUSH) begin
      flush       = 1'b1;
      pc_redirect = 1'b1;
    end else if (stall_ok) begin
      if (data_sram_wait) begin
        if_stall    = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_stall = 1'b1;
      end else if (div_busy_w) begin
        // EX/MEM input is gated to a bubble with div_busy at the top level.
        if_stall   = 1'b1;
        idex_stall = 1'b1;
      end else if (load_use || inst_sram_wait) begin
        if_stall    = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic        cause_mem, cause_div, cause_lu;
  logic [31:0] loaduse_q, div_stall_q, mem_stall_q;

  assign cause_mem = stall_ok && data_sram_wait;
  assign cause_div = stall_ok && !data_sram_wait && div_busy_w;
  assign cause_lu  = stall_ok && !data_sram_wait && !div_busy_w && load_use;

  // Count cycles in which each stall cause is the winning one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaduse_q   <= '0;
      div_stall_q <= '0;
      mem_stall_q <= '0;
    end else begin
      if (cause_lu)  loaduse_q   <= loaduse_q + 32'd1;
      if (cause_div) div_stall_q <= div_stall_q + 32'd1;
      if (cause_mem) mem_stall_q <= mem_stall_q + 32'd1;
    end
  end

  assign loaduse_cnt   = loaduse_q;
  assign div_stall_cnt = div_stall_q;
  assign mem_stall_cnt = mem_stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected output vectors are queued as
// each cycle's stimulus is applied and checked once the outputs settle.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_write_dst;
  logic        id_use_rs, id_use_rt, ex_is_load, ex_write_reg, ex_div_start;
  logic        inst_sram_wait, data_sram_wait, exc_req, eret_req;
  logic [31:0] epc;
  logic        if_stall, idex_stall, exmem_stall, memwb_stall, idex_bubble;
  logic        flush, pc_redirect, div_busy, div_done;
  logic [31:0] redirect_pc;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] loaduse_cnt, div_stall_cnt, mem_stall_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .ex_is_load     (ex_is_load),
    .ex_write_reg   (ex_write_reg),
    .ex_write_dst   (ex_write_dst),
    .ex_div_start   (ex_div_start),
    .inst_sram_wait (inst_sram_wait),
    .data_sram_wait (data_sram_wait),
    .exc_req        (exc_req),
    .eret_req       (eret_req),
    .epc            (epc),
    .if_stall       (if_stall),
    .idex_stall     (idex_stall),
    .exmem_stall    (exmem_stall),
    .memwb_stall    (memwb_stall),
    .idex_bubble    (idex_bubble),
    .flush          (flush),
    .pc_redirect    (pc_redirect),
    .redirect_pc    (redirect_pc),
    .div_busy       (div_busy),
    .div_done       (div_done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .loaduse_cnt    (loaduse_cnt),
    .div_stall_cnt  (div_stall_cnt),
    .mem_stall_cnt  (mem_stall_cnt)
`endif
  );

  typedef logic [40:0] vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;
  logic [31:0] rpc;
  vec_t  obs;

  assign obs = {if_stall, idex_stall, exmem_stall, memwb_stall, idex_bubble,
                flush, pc_redirect, div_busy, div_done, redirect_pc};

  // Field order: if, idex, exmem, memwb, bubble, flush, redirect, busy, done, pc
  function automatic vec_t ev(bit ifs, bit ids, bit ems, bit mws, bit bub,
                              bit fl, bit pr, bit busy, bit done,
                              logic [31:0] pc);
    return {ifs, ids, ems, mws, bub, fl, pr, busy, done, pc};
  endfunction

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    ex_is_load = 0; ex_write_reg = 0; ex_write_dst = '0; ex_div_start = 0;
    inst_sram_wait = 0; data_sram_wait = 0; exc_req = 0; eret_req = 0;
    epc = '0;
  endtask

  // lw $2 in EX, addu $3,$2,$4 in ID
  task automatic set_load_use();
    ex_is_load = 1; ex_write_reg = 1; ex_write_dst = 5'd2;
    id_rs = 5'd2; id_use_rs = 1; id_rt = 5'd4; id_use_rt = 1;
  endtask

  task automatic check_one();
    vec_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
  endtask

  // Called at a falling edge after inputs are driven; checks, then advances.
  task automatic tick(input string tag, input vec_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check_one();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle();
    rpc = 32'h0;
    @(negedge clk);
    tick("reset", ev(0,0,0,0,0,0,0,0,0, 32'h0));
    rst_n = 1;
    tick("idle", ev(0,0,0,0,0,0,0,0,0, rpc));

    // load-use: one bubble, then the load leaves EX
    set_load_use();
    tick("lu_rs", ev(1,0,0,0,1,0,0,0,0, rpc));
    ex_is_load = 0; ex_write_reg = 0; ex_write_dst = '0;
    tick("lu_release", ev(0,0,0,0,0,0,0,0,0, rpc));
    idle();
    ex_is_load = 1; ex_write_reg = 1; ex_write_dst = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    tick("lu_r0", ev(0,0,0,0,0,0,0,0,0, rpc));
    id_rs = 5'd3; id_rt = 5'd5; ex_write_dst = 5'd5; id_use_rt = 1;
    tick("lu_rt", ev(1,0,0,0,1,0,0,0,0, rpc));
    id_use_rt = 0;
    tick("lu_rt_unused", ev(0,0,0,0,0,0,0,0,0, rpc));
    id_use_rt = 1; ex_write_reg = 0;
    tick("lu_nowrite", ev(0,0,0,0,0,0,0,0,0, rpc));
    ex_write_reg = 1; ex_is_load = 0;
    tick("lu_notload", ev(0,0,0,0,0,0,0,0,0, rpc));

    // memory wait states and their priority
    idle(); inst_sram_wait = 1;
    tick("iwait", ev(1,0,0,0,1,0,0,0,0, rpc));
    idle(); data_sram_wait = 1;
    tick("dwait", ev(1,1,1,1,0,0,0,0,0, rpc));
    set_load_use();
    tick("dwait_lu", ev(1,1,1,1,0,0,0,0,0, rpc));
    data_sram_wait = 0; inst_sram_wait = 1;
    tick("lu_iwait", ev(1,0,0,0,1,0,0,0,0, rpc));
    idle();

    // plain division, load-use in ID masked by the divider
    ex_div_start = 1;
    tick("div_start", ev(1,1,0,0,0,0,0,1,0, rpc));
    ex_div_start = 0;
    set_load_use();
    for (int k = 2; k <= 32; k++)
      tick($sformatf("div_c%0d", k), ev(1,1,0,0,0,0,0,1, (k == 32), rpc));
    tick("div_end_lu", ev(1,0,0,0,1,0,0,0,0, rpc));
    idle();
    tick("div_idle", ev(0,0,0,0,0,0,0,0,0, rpc));

    // data wait for 3 cycles while the counter shows 10
    ex_div_start = 1;
    tick("divw_start", ev(1,1,0,0,0,0,0,1,0, rpc));
    ex_div_start = 0;
    for (int k = 2; k <= 35; k++) begin
      data_sram_wait = (k >= 23 && k <= 25);
      if (data_sram_wait)
        tick($sformatf("divw_c%0d", k), ev(1,1,1,1,0,0,0,1,0, rpc));
      else
        tick($sformatf("divw_c%0d", k), ev(1,1,0,0,0,0,0,1, (k == 35), rpc));
    end
    data_sram_wait = 0;
    tick("divw_idle", ev(0,0,0,0,0,0,0,0,0, rpc));

    // exception while the counter shows 5
    ex_div_start = 1;
    tick("dive_start", ev(1,1,0,0,0,0,0,1,0, rpc));
    ex_div_start = 0;
    for (int k = 2; k <= 27; k++)
      tick($sformatf("dive_c%0d", k), ev(1,1,0,0,0,0,0,1,0, rpc));
    exc_req = 1;
    tick("dive_exc", ev(0,0,0,0,0,0,0,1,0, rpc));
    exc_req = 0;
    rpc = 32'hbfc00380;
    tick("dive_flush", ev(0,0,0,0,0,1,1,0,0, rpc));
    for (int k = 0; k < 6; k++)
      tick($sformatf("dive_post%0d", k), ev(0,0,0,0,0,0,0,0,0, rpc));

    // ERET together with a load-use hazard
    epc = 32'h80001234; eret_req = 1;
    set_load_use();
    tick("eret_lu", ev(0,0,0,0,0,0,0,0,0, rpc));
    eret_req = 0;
    rpc = 32'h80001234;
    tick("eret_flush_lu", ev(0,0,0,0,0,1,1,0,0, rpc));
    idle();
    tick("eret_post", ev(0,0,0,0,0,0,0,0,0, rpc));

    // exception and ERET together: exception vector wins
    exc_req = 1; eret_req = 1; epc = 32'h11110000;
    tick("both_req", ev(0,0,0,0,0,0,0,0,0, rpc));
    idle();
    rpc = 32'hbfc00380;
    tick("both_flush", ev(0,0,0,0,0,1,1,0,0, rpc));
    tick("both_post", ev(0,0,0,0,0,0,0,0,0, rpc));

    // back-to-back ERETs keep the controller in FLUSH
    eret_req = 1; epc = 32'h0000a000;
    tick("b2b_req1", ev(0,0,0,0,0,0,0,0,0, rpc));
    epc = 32'h0000b000;
    rpc = 32'h0000a000;
    tick("b2b_req2", ev(0,0,0,0,0,1,1,0,0, rpc));
    idle();
    rpc = 32'h0000b000;
    tick("b2b_flush2", ev(0,0,0,0,0,1,1,0,0, rpc));
    tick("b2b_post", ev(0,0,0,0,0,0,0,0,0, rpc));

    // reset in the middle of FLUSH
    eret_req = 1; epc = 32'hdeadbeef;
    tick("rf_req", ev(0,0,0,0,0,0,0,0,0, rpc));
    eret_req = 0; epc = '0;
    rst_n = 0;
    tick("rf_in_reset", ev(0,0,0,0,0,0,0,0,0, 32'h0));
    rst_n = 1;
    rpc = 32'h0;
    tick("rf_post", ev(0,0,0,0,0,0,0,0,0, rpc));

    // reset in the middle of a division: abandoned, no div_done
    ex_div_start = 1;
    tick("rd_start", ev(1,1,0,0,0,0,0,1,0, rpc));
    ex_div_start = 0;
    for (int k = 2; k <= 10; k++)
      tick($sformatf("rd_c%0d", k), ev(1,1,0,0,0,0,0,1,0, rpc));
    rst_n = 0;
    tick("rd_in_reset", ev(0,0,0,0,0,0,0,0,0, 32'h0));
    rst_n = 1;
    for (int k = 0; k < 5; k++)
      tick($sformatf("rd_post%0d", k), ev(0,0,0,0,0,0,0,0,0, rpc));

    // divider restarts cleanly after the reset
    ex_div_start = 1;
    tick("rd_restart", ev(1,1,0,0,0,0,0,1,0, rpc));
    ex_div_start = 0;
    tick("rd_restart_c2", ev(1,1,0,0,0,0,0,1,0, rpc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
